busmaster_v2: RTL

//  Second-generation register-bus master: decodes a host command stream (cmd FIFO) into slave

---
 rtl/busmaster_v2_if.sv | 42 ++++
 rtl/busmaster_v2.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/busmaster_v2_if.sv
// Host and register-bus signal bundle of busmaster_v2.
//   master modport : busmaster_v2 side (takes commands, yields responses, drives the slave bus)
//   slave  modport : environment side (host FIFO access plus register slave)
// Signals:
//   cmd_data_i/cmd_we_i/cmd_full_o                 command FIFO push side
//   rsp_data_o/rsp_pktend_o/rsp_re_i/rsp_empty_o   response FIFO pop side
//   modaddr_o/regaddr_o/regdata_o/we_o/re_o        registered slave bus outputs
//   regdata_i                                      slave read data
interface busmaster_v2_if #(
    parameter int unsigned MOD_W  = 5,
    parameter int unsigned REG_W  = 8,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned CMD_W = 3 + MOD_W + REG_W + DATA_W;
    localparam int unsigned RSP_W = 8 + REG_W + DATA_W;

    logic [CMD_W-1:0]  cmd_data_i;
    logic              cmd_we_i;
    logic              cmd_full_o;
    logic [RSP_W-1:0]  rsp_data_o;
    logic              rsp_pktend_o;
    logic              rsp_re_i;
    logic              rsp_empty_o;
    logic [MOD_W-1:0]  modaddr_o;
    logic [REG_W-1:0]  regaddr_o;
    logic [DATA_W-1:0] regdata_o;
    logic              we_o;
    logic              re_o;
    logic [DATA_W-1:0] regdata_i;

    modport master (
        input  cmd_data_i, cmd_we_i, rsp_re_i, regdata_i,
        output cmd_full_o, rsp_data_o, rsp_pktend_o, rsp_empty_o,
        output modaddr_o, regaddr_o, regdata_o, we_o, re_o
    );

    modport slave (
        output cmd_data_i, cmd_we_i, rsp_re_i, regdata_i,
        input  cmd_full_o, rsp_data_o, rsp_pktend_o, rsp_empty_o,
        input  modaddr_o, regaddr_o, regdata_o, we_o, re_o
    );
endinterface

// File: rtl/busmaster_v2.sv
// Register-bus master: pops host commands from a cmd FIFO, runs slave register
// read/write/RMW/burst cycles and pushes tagged read responses into a rsp FIFO.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous reset, active low
//   bus        busmaster_v2_if.master (cmd/rsp FIFOs and slave register bus)
//   busy_o     FSM not idle
//   err_cnt_o  saturating count of reserved opcodes
module busmaster_v2 #(
    parameter int unsigned MOD_W     = 5,
    parameter int unsigned REG_W     = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CMD_DEPTH = 16,
    parameter int unsigned RSP_DEPTH = 16,
    parameter int unsigned RD_LAT    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    busmaster_v2_if.master        bus,
    output logic                  busy_o,
    output logic [7:0]            err_cnt_o
);
    localparam int unsigned CMD_W  = 3 + MOD_W + REG_W + DATA_W;
    localparam int unsigned RSP_W  = 8 + REG_W + DATA_W;
    localparam int unsigned CAW    = $clog2(CMD_DEPTH);
    localparam int unsigned RAW    = $clog2(RSP_DEPTH);
    localparam int unsigned WAIT_W = CMD_W - 3;
    localparam int unsigned LAT_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_ISSUE, ST_RDWAIT, ST_WAIT, ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        OP_READ  = 3'b000, OP_READX = 3'b001, OP_WRITE = 3'b010, OP_WAIT = 3'b011,
        OP_SETB  = 3'b100, OP_CLRB  = 3'b101, OP_BURST = 3'b110, OP_RSV  = 3'b111
    } op_t;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]   cmd_wp, cmd_rp;
    logic [CAW:0]     cmd_cnt;
    logic             cmd_push, cmd_pop, cmd_empty;
    logic [CMD_W-1:0] cmd_q;

    assign bus.cmd_full_o = (cmd_cnt == (CAW+1)'(CMD_DEPTH));
    assign cmd_empty      = (cmd_cnt == '0);
    assign cmd_push       = bus.cmd_we_i && !bus.cmd_full_o;

    always_ff @(posedge clk_i) begin
        if (cmd_push) cmd_mem[cmd_wp] <= bus.cmd_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
            cmd_q   <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + CAW'(1);
            if (cmd_pop) begin
                cmd_rp <= cmd_rp + CAW'(1);
                cmd_q  <= cmd_mem[cmd_rp];
            end
            cmd_cnt <= cmd_cnt + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
        end
    end

    // ---------------- response FIFO (bit RSP_W carries pktend) ----------------
    logic [RSP_W:0] rsp_mem [RSP_DEPTH];
    logic [RAW-1:0] rsp_wp, rsp_rp;
    logic [RAW:0]   rsp_cnt;
    logic           rsp_push, rsp_pop, rsp_full;
    logic [RSP_W:0] rsp_wdata;

    assign rsp_full         = (rsp_cnt == (RAW+1)'(RSP_DEPTH));
    assign bus.rsp_empty_o  = (rsp_cnt == '0);
    assign rsp_pop          = bus.rsp_re_i && !bus.rsp_empty_o;
    assign bus.rsp_data_o   = rsp_mem[rsp_rp][RSP_W-1:0];
    assign bus.rsp_pktend_o = rsp_mem[rsp_rp][RSP_W];

    always_ff @(posedge clk_i) begin
        if (rsp_push) rsp_mem[rsp_wp] <= rsp_wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (rsp_push) rsp_wp <= rsp_wp + RAW'(1);
            if (rsp_pop)  rsp_rp <= rsp_rp + RAW'(1);
            rsp_cnt <= rsp_cnt + (RAW+1)'(rsp_push) - (RAW+1)'(rsp_pop);
        end
    end

    // ---------------- command FSM ----------------
    state_t              state_q, state_d;
    logic [MOD_W-1:0]    mod_q, mod_d;
    logic [REG_W-1:0]    reg_q, reg_d, rd_reg_q, rd_reg_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic                we_q, we_d, re_q, re_d;
    logic [7:0]          burst_q, burst_d, err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    op_t                 op;
    logic [MOD_W-1:0]    c_mod;
    logic [REG_W-1:0]    c_reg;
    logic [DATA_W-1:0]   c_data;
    logic                is_rmw, issue_ok, last_word;

    assign op        = op_t'(cmd_q[CMD_W-1 -: 3]);
    assign c_mod     = cmd_q[CMD_W-4 -: MOD_W];
    assign c_reg     = cmd_q[DATA_W +: REG_W];
    assign c_data    = cmd_q[DATA_W-1:0];
    assign is_rmw    = (op == OP_SETB) || (op == OP_CLRB);
    // RMW never produces a response, so it need not wait for rsp space.
    assign issue_ok  = is_rmw || !rsp_full;
    assign last_word = (op == OP_READ) || ((op == OP_BURST) && (burst_q == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            mod_q    <= '0;
            reg_q    <= '0;
            rd_reg_q <= '0;
            wdat_q   <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            burst_q  <= '0;
            err_q    <= '0;
            wait_q   <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            mod_q    <= mod_d;
            reg_q    <= reg_d;
            rd_reg_q <= rd_reg_d;
            wdat_q   <= wdat_d;
            we_q     <= we_d;
            re_q     <= re_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            lat_q    <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!cmd_empty) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_WRITE: state_d = ST_IDLE;
                    OP_WAIT:  state_d = ST_WAIT;
                    OP_RSV:   state_d = ST_ERR;
                    default:  state_d = ST_ISSUE;
                endcase
            end
            ST_ISSUE:  if (issue_ok) state_d = ST_RDWAIT;
            ST_RDWAIT: begin
                if (lat_q == '0)
                    state_d = ((op == OP_BURST) && (burst_q != '0)) ? ST_ISSUE : ST_IDLE;
            end
            ST_WAIT:   if (wait_q == '0) state_d = ST_IDLE;
            ST_ERR:    if (!rsp_full) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mod_d     = mod_q;
        reg_d     = reg_q;
        rd_reg_d  = rd_reg_q;
        wdat_d    = wdat_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        burst_d   = burst_q;
        err_d     = err_q;
        wait_d    = wait_q;
        lat_d     = lat_q;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_wdata = '0;
        case (state_q)
            ST_IDLE: cmd_pop = !cmd_empty;
            ST_DECODE: begin
                rd_reg_d = c_reg;
                burst_d  = (op == OP_BURST) ? c_data[7:0] : 8'd0;
                wait_d   = cmd_q[WAIT_W-1:0];
                if (op == OP_WRITE) begin
                    mod_d  = c_mod;
                    reg_d  = c_reg;
                    wdat_d = c_data;
                    we_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (issue_ok) begin
                    mod_d = c_mod;
                    reg_d = rd_reg_q;
                    re_d  = 1'b1;
                    lat_d = LAT_W'(RD_LAT);
                end
            end
            ST_RDWAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LAT_W'(1);
                end else if (op == OP_SETB) begin
                    wdat_d = bus.regdata_i | c_data;
                    we_d   = 1'b1;
                end else if (op == OP_CLRB) begin
                    wdat_d = bus.regdata_i & ~c_data;
                    we_d   = 1'b1;
                end else begin
                    rsp_push  = 1'b1;
                    rsp_wdata = {last_word, 8'hD1, rd_reg_q, bus.regdata_i};
                    rd_reg_d  = rd_reg_q + REG_W'(1);
                    if (burst_q != '0) burst_d = burst_q - 8'd1;
                end
            end
            ST_WAIT: if (wait_q != '0) wait_d = wait_q - WAIT_W'(1);
            ST_ERR: begin
                if (!rsp_full) begin
                    rsp_push  = 1'b1;
                    rsp_wdata = {1'b1, 8'hEE, c_reg, DATA_W'(0)};
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.modaddr_o = mod_q;
    assign bus.regaddr_o = reg_q;
    assign bus.regdata_o = wdat_q;
    assign bus.we_o      = we_q;
    assign bus.re_o      = re_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign err_cnt_o     = err_q;
endmodule
